// File: rtl/output_buffer_filler_pkg.sv
// Shared types and constants for the output buffer filler.
//   VADDR_BITS : virtual address width of a host buffer
//   LEN_BITS   : byte-length width of buffer sizes and completion byte counts
//   BEAT_BYTES : bytes per data beat (power of two)
//   buffer_t   : host buffer descriptor {vaddr, size}
//   cmpl_t     : completion descriptor {vaddr, bytes, stream_end}
//   state_t    : filler FSM states
package output_buffer_filler_pkg;

    localparam int VADDR_BITS = 48;
    localparam int LEN_BITS   = 28;
    localparam int BEAT_BYTES = 64;
    localparam int DATA_BITS  = BEAT_BYTES * 8;

    localparam logic [LEN_BITS-1:0] BEAT_LEN  = LEN_BITS'(BEAT_BYTES);
    localparam logic [LEN_BITS-1:0] BEAT_MASK = ~(BEAT_LEN - 1'b1);

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   size;
    } buffer_t;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   bytes;
        logic                  stream_end;
    } cmpl_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE,
        S_FLUSH
    } state_t;

    // Only whole beats fit into a host buffer, so any partial tail is ignored.
    function automatic logic [LEN_BITS-1:0] beat_align(input logic [LEN_BITS-1:0] size);
        return size & BEAT_MASK;
    endfunction

endpackage

// File: rtl/output_buffer_filler_if.sv
// Handshake bundle around the output buffer filler.
//   buf_*  : descriptor channel from the memory config block
//   din_*  : incoming data beats
//   dout_* : outgoing data beats with their write address
//   cmpl_* : completion descriptors
// master = environment side, slave = filler side.
interface output_buffer_filler_if;
    import output_buffer_filler_pkg::*;

    logic                  buf_valid;
    logic                  buf_ready;
    buffer_t               buf_data;

    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_BITS-1:0]  din_data;
    logic                  din_last;

    logic                  dout_valid;
    logic                  dout_ready;
    logic [DATA_BITS-1:0]  dout_data;
    logic                  dout_last;
    logic [VADDR_BITS-1:0] dout_addr;

    logic                  cmpl_valid;
    logic                  cmpl_ready;
    cmpl_t                 cmpl_data;

    modport master (
        output buf_valid, buf_data,
        input  buf_ready,
        output din_valid, din_data, din_last,
        input  din_ready,
        input  dout_valid, dout_data, dout_last, dout_addr,
        output dout_ready,
        input  cmpl_valid, cmpl_data,
        output cmpl_ready
    );

    modport slave (
        input  buf_valid, buf_data,
        output buf_ready,
        input  din_valid, din_data, din_last,
        output din_ready,
        output dout_valid, dout_data, dout_last, dout_addr,
        input  dout_ready,
        output cmpl_valid, cmpl_data,
        input  cmpl_ready
    );

endinterface

// File: rtl/output_buffer_filler.sv
// Maps an outgoing beat stream onto host buffers handed over by the memory
// config block. Every beat gets a virtual write address; a completion is
// emitted when a buffer fills up or the stream ends. A flush discards stale
// descriptors and reports how many were thrown away.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_buffers : single-cycle flush request
//   flush_done    : single-cycle pulse when the flush drain finishes
//   dropped_bufs  : saturating count of discarded descriptors
//   bus           : descriptor / beat / completion handshakes (slave side)
module output_buffer_filler
    import output_buffer_filler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_buffers,
    output logic                  flush_done,
    output logic [15:0]           dropped_bufs,
    output_buffer_filler_if.slave bus
);

    state_t                state, state_nxt;
    logic [VADDR_BITS-1:0] vaddr_r, vaddr_nxt;
    logic [LEN_BITS-1:0]   size_r, size_nxt;
    logic [LEN_BITS-1:0]   offset_r, offset_nxt;
    cmpl_t                 cmpl_r, cmpl_nxt;
    logic                  flush_pend, flush_pend_nxt;
    logic                  drop_evt;

    logic                  buf_hs;
    logic                  beat_hs;
    logic                  cmpl_hs;
    logic [LEN_BITS-1:0]   offset_inc;
    logic [LEN_BITS-1:0]   size_aligned;

    // Descriptor accept is held low while reset is asserted, not just after it.
    assign bus.buf_ready  = !rst && ((state == S_IDLE) || (state == S_FLUSH));
    assign bus.din_ready  = (state == S_FILL) && bus.dout_ready;
    assign bus.dout_valid = (state == S_FILL) && bus.din_valid;
    assign bus.cmpl_valid = (state == S_DONE);

    assign bus.dout_data  = bus.din_data;
    assign bus.dout_last  = bus.din_last;
    assign bus.dout_addr  = vaddr_r + VADDR_BITS'(offset_r);
    assign bus.cmpl_data  = cmpl_r;

    assign buf_hs       = bus.buf_valid && bus.buf_ready;
    assign beat_hs      = bus.din_valid && bus.din_ready;
    assign cmpl_hs      = bus.cmpl_valid && bus.cmpl_ready;
    assign offset_inc   = offset_r + BEAT_LEN;
    assign size_aligned = beat_align(bus.buf_data.size);

    // Next-state logic: buffer capture, beat accounting, completion building
    // and flush handling. A flush that arrives once a buffer has taken data
    // is deferred until that buffer's completion has been handed off.
    always_comb begin
        state_nxt      = state;
        vaddr_nxt      = vaddr_r;
        size_nxt       = size_r;
        offset_nxt     = offset_r;
        cmpl_nxt       = cmpl_r;
        flush_pend_nxt = flush_pend;
        drop_evt       = 1'b0;
        flush_done     = 1'b0;

        case (state)
            S_IDLE: begin
                if (flush_buffers) begin
                    drop_evt  = buf_hs;
                    state_nxt = S_FLUSH;
                end else if (buf_hs) begin
                    vaddr_nxt  = bus.buf_data.vaddr;
                    size_nxt   = size_aligned;
                    offset_nxt = '0;
                    if (size_aligned == '0) begin
                        cmpl_nxt  = '{vaddr: bus.buf_data.vaddr, bytes: '0, stream_end: 1'b0};
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FILL;
                    end
                end
            end

            S_FILL: begin
                // An untouched buffer can be discarded outright on flush.
                if (flush_buffers && (offset_r == '0) && !beat_hs) begin
                    drop_evt  = 1'b1;
                    state_nxt = S_FLUSH;
                end else begin
                    if (flush_buffers) begin
                        flush_pend_nxt = 1'b1;
                    end
                    if (beat_hs) begin
                        offset_nxt = offset_inc;
                        if ((offset_inc == size_r) || bus.din_last) begin
                            cmpl_nxt  = '{vaddr: vaddr_r, bytes: offset_inc, stream_end: bus.din_last};
                            state_nxt = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                if (flush_buffers) begin
                    flush_pend_nxt = 1'b1;
                end
                if (cmpl_hs) begin
                    state_nxt = (flush_pend || flush_buffers) ? S_FLUSH : S_IDLE;
                end
            end

            S_FLUSH: begin
                drop_evt = buf_hs;
                if (!bus.buf_valid) begin
                    flush_done     = 1'b1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            vaddr_r    <= '0;
            size_r     <= '0;
            offset_r   <= '0;
            cmpl_r     <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            vaddr_r    <= vaddr_nxt;
            size_r     <= size_nxt;
            offset_r   <= offset_nxt;
            cmpl_r     <= cmpl_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Dropped-descriptor counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_bufs <= '0;
        end else if (drop_evt && (dropped_bufs != 16'hFFFF)) begin
            dropped_bufs <= dropped_bufs + 16'd1;
        end
    end

endmodule

// File: tb/tb_output_buffer_filler.sv
// Directed bench for output_buffer_filler. A queue-based model turns each
// descriptor list plus beat count into the expected beat addresses, payloads
// and completions; a single compare process checks every accepted beat and
// completion against it. Flush and reset behaviour is checked with literal
// expectations.
module tb_output_buffer_filler;
    import output_buffer_filler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_buffers = 1'b0;
    logic        flush_done;
    logic [15:0] dropped_bufs;

    output_buffer_filler_if bus();

    output_buffer_filler dut (
        .clk           (clk),
        .rst           (rst),
        .flush_buffers (flush_buffers),
        .flush_done    (flush_done),
        .dropped_bufs  (dropped_bufs),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int flush_done_cnt = 0;
    bit use_rand_ready = 1'b0;
    bit flush_sent = 1'b0;

    logic [VADDR_BITS-1:0] exp_addr_q[$];
    logic [DATA_BITS-1:0]  exp_data_q[$];
    cmpl_t                 exp_cmpl_q[$];

    function automatic logic [DATA_BITS-1:0] beat_word(input int n);
        return {(DATA_BITS/32){32'hBEE0_0000 | 32'(n)}};
    endfunction

    function automatic cmpl_t mk_cmpl(input longint va, input int bytes, input bit se);
        cmpl_t c;
        c.vaddr      = VADDR_BITS'(va);
        c.bytes      = LEN_BITS'(bytes);
        c.stream_end = se;
        return c;
    endfunction

    function automatic buffer_t mk_buf(input longint va, input int sz);
        buffer_t b;
        b.vaddr = VADDR_BITS'(va);
        b.size  = LEN_BITS'(sz);
        return b;
    endfunction

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for handshake", name);
    endtask

    // Model: fill each buffer with whole beats in order; the last beat of the
    // stream is the final one given. Zero-capacity buffers complete empty.
    task automatic model_stream(input buffer_t d[$], input int nbeats, input int base);
        int bi = 0;
        foreach (d[k]) begin
            int     cap;
            int     off;
            longint va;
            cap = (int'(d[k].size) / BEAT_BYTES) * BEAT_BYTES;
            va  = longint'(d[k].vaddr);
            off = 0;
            if (cap == 0) begin
                exp_cmpl_q.push_back(mk_cmpl(va, 0, 1'b0));
            end else begin
                while (bi < nbeats) begin
                    exp_addr_q.push_back(VADDR_BITS'(va + longint'(off)));
                    exp_data_q.push_back(beat_word(base + bi));
                    off += BEAT_BYTES;
                    bi++;
                    if (off == cap || bi == nbeats) begin
                        exp_cmpl_q.push_back(mk_cmpl(va, off, bi == nbeats));
                        break;
                    end
                end
            end
        end
    endtask

    task automatic send_desc(input buffer_t b);
        bit hs = 1'b0;
        bus.buf_valid = 1'b1;
        bus.buf_data  = b;
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge clk);
            hs = bus.buf_ready;
            @(posedge clk);
            #1;
        end
        bus.buf_valid = 1'b0;
        if (!hs) timeout_fail("buf_handshake");
    endtask

    task automatic send_beat(input int n, input bit last);
        bit hs = 1'b0;
        bus.din_valid = 1'b1;
        bus.din_data  = beat_word(n);
        bus.din_last  = last;
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge clk);
            hs = bus.din_ready;
            @(posedge clk);
            #1;
        end
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
        if (!hs) timeout_fail("beat_handshake");
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_addr_q.size() != 0 || exp_cmpl_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_cmpl_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d beats and %0d completions outstanding, expected 0",
                     name, exp_addr_q.size(), exp_cmpl_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Descriptors and beats are driven concurrently, as the config block and
    // the data path would.
    task automatic apply_stimulus(input buffer_t d[$], input int nbeats, input int base);
        fork
            begin
                foreach (d[k]) send_desc(d[k]);
            end
            begin
                for (int i = 0; i < nbeats; i++) send_beat(base + i, i == nbeats - 1);
            end
        join
    endtask

    initial begin
        bus.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_ready = use_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every accepted beat and completion is checked.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.dout_valid && bus.dout_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: addr %0h accepted, expected none", bus.dout_addr);
                    end else begin
                        check_output("dout_addr", 512'(bus.dout_addr), 512'(exp_addr_q.pop_front()));
                        check_output("dout_data", bus.dout_data, exp_data_q.pop_front());
                    end
                end
                if (bus.cmpl_valid && bus.cmpl_ready) begin
                    if (exp_cmpl_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_cmpl: got %0h, expected none", bus.cmpl_data);
                    end else begin
                        check_output("cmpl_data", 512'(bus.cmpl_data), 512'(exp_cmpl_q.pop_front()));
                    end
                end
                if (flush_done) flush_done_cnt++;
            end
        end
    end

    initial begin
        buffer_t d[$];
        int      fd_before;
        int      n;

        bus.buf_valid  = 1'b0;
        bus.buf_data   = '0;
        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus.din_last   = 1'b0;
        bus.cmpl_ready = 1'b1;

        // Reset state
        #1;
        check_output("rst_buf_ready", 512'(bus.buf_ready), 512'(0));
        check_output("rst_din_ready", 512'(bus.din_ready), 512'(0));
        check_output("rst_dout_valid", 512'(bus.dout_valid), 512'(0));
        check_output("rst_cmpl_valid", 512'(bus.cmpl_valid), 512'(0));
        check_output("rst_flush_done", 512'(flush_done), 512'(0));
        check_output("rst_dropped", 512'(dropped_bufs), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: one buffer, four beats, last on the fourth
        $display("[TB] T1 single buffer");
        d = {mk_buf(64'h1000, 256)};
        model_stream(d, 4, 100);
        check_output("t1_model_addr3", 512'(exp_addr_q[3]), 512'(48'h10C0));
        check_output("t1_model_cmpl", 512'(exp_cmpl_q[0]), 512'({48'h1000, 28'd256, 1'b1}));
        apply_stimulus(d, 4, 100);
        wait_drain("t1");

        // T2: buffer boundary crossed mid-stream
        $display("[TB] T2 two buffers");
        d = {mk_buf(64'h1000, 128), mk_buf(64'h2000, 256)};
        model_stream(d, 3, 200);
        check_output("t2_model_addr2", 512'(exp_addr_q[2]), 512'(48'h2000));
        check_output("t2_model_cmpl0", 512'(exp_cmpl_q[0]), 512'({48'h1000, 28'd128, 1'b0}));
        check_output("t2_model_cmpl1", 512'(exp_cmpl_q[1]), 512'({48'h2000, 28'd64, 1'b1}));
        apply_stimulus(d, 3, 200);
        wait_drain("t2");

        // T3: random dout_ready, completions held off for five cycles
        $display("[TB] T3 backpressure");
        use_rand_ready = 1'b1;
        bus.cmpl_ready = 1'b0;
        d = {mk_buf(64'h4000, 128), mk_buf(64'h5000, 128)};
        model_stream(d, 4, 300);
        check_output("t3_model_cmpl1", 512'(exp_cmpl_q[1]), 512'({48'h5000, 28'd128, 1'b1}));
        fork
            apply_stimulus(d, 4, 300);
            begin
                for (int c = 0; c < 2; c++) begin
                    n = 0;
                    while (!bus.cmpl_valid && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!bus.cmpl_valid) begin
                        timeout_fail("t3_cmpl_valid");
                    end else begin
                        check_output("t3_stall_din_ready", 512'(bus.din_ready), 512'(0));
                        for (int s = 1; s < 5; s++) begin
                            @(negedge clk);
                            check_output("t3_stall_din_ready", 512'(bus.din_ready), 512'(0));
                            check_output("t3_stall_cmpl_valid", 512'(bus.cmpl_valid), 512'(1));
                        end
                    end
                    @(posedge clk);
                    #1;
                    bus.cmpl_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.cmpl_ready = 1'b0;
                end
            end
        join
        bus.cmpl_ready = 1'b1;
        wait_drain("t3");
        use_rand_ready = 1'b0;

        // T4: flush in IDLE with three descriptors queued
        $display("[TB] T4 flush from idle");
        fd_before = flush_done_cnt;
        fork
            begin
                flush_buffers = 1'b1;
                @(posedge clk);
                #1;
                flush_buffers = 1'b0;
            end
            begin
                send_desc(mk_buf(64'hA000, 256));
                send_desc(mk_buf(64'hB000, 256));
                send_desc(mk_buf(64'hC000, 256));
            end
        join
        repeat (4) @(negedge clk);
        check_output("t4_dropped", 512'(dropped_bufs), 512'(3));
        check_output("t4_flush_done_cnt", 512'(flush_done_cnt - fd_before), 512'(1));
        check_output("t4_cmpl_valid", 512'(bus.cmpl_valid), 512'(0));
        @(posedge clk);
        #1;

        // T5: flush while filling at offset 128, two descriptors queued behind
        $display("[TB] T5 flush during fill");
        fd_before = flush_done_cnt;
        flush_sent = 1'b0;
        d = {mk_buf(64'h1000, 512)};
        model_stream(d, 4, 400);
        check_output("t5_model_cmpl", 512'(exp_cmpl_q[0]), 512'({48'h1000, 28'd256, 1'b1}));
        fork
            begin
                send_desc(d[0]);
                n = 0;
                while (!flush_sent && n < 400) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                send_desc(mk_buf(64'h6000, 128));
                send_desc(mk_buf(64'h7000, 128));
            end
            begin
                send_beat(400, 1'b0);
                send_beat(401, 1'b0);
                flush_buffers = 1'b1;
                flush_sent = 1'b1;
                @(posedge clk);
                #1;
                flush_buffers = 1'b0;
                send_beat(402, 1'b0);
                send_beat(403, 1'b1);
            end
        join
        wait_drain("t5");
        repeat (3) @(negedge clk);
        check_output("t5_dropped", 512'(dropped_bufs), 512'(5));
        check_output("t5_flush_done_cnt", 512'(flush_done_cnt - fd_before), 512'(1));
        @(posedge clk);
        #1;

        // Flush on an untouched buffer drops that buffer itself
        $display("[TB] T5b flush at offset 0");
        fd_before = flush_done_cnt;
        send_desc(mk_buf(64'h8000, 256));
        flush_buffers = 1'b1;
        @(posedge clk);
        #1;
        flush_buffers = 1'b0;
        repeat (3) @(negedge clk);
        check_output("t5b_dropped", 512'(dropped_bufs), 512'(6));
        check_output("t5b_flush_done_cnt", 512'(flush_done_cnt - fd_before), 512'(1));
        check_output("t5b_cmpl_valid", 512'(bus.cmpl_valid), 512'(0));
        @(posedge clk);
        #1;

        // T6: sub-beat buffer completes empty without consuming the waiting beat
        $display("[TB] T6 tiny buffer and reset");
        d = {mk_buf(64'h3000, 32), mk_buf(64'h3100, 64)};
        model_stream(d, 1, 500);
        check_output("t6_model_cmpl0", 512'(exp_cmpl_q[0]), 512'({48'h3000, 28'd0, 1'b0}));
        apply_stimulus(d, 1, 500);
        wait_drain("t6");

        // Reset asserted mid-fill: everything drops immediately
        exp_addr_q.push_back(48'h9000);
        exp_data_q.push_back(beat_word(600));
        fork
            send_desc(mk_buf(64'h9000, 256));
            send_beat(600, 1'b0);
        join
        bus.din_valid = 1'b1;
        bus.din_data  = beat_word(601);
        #1;
        rst = 1'b1;
        #1;
        check_output("midrst_dout_valid", 512'(bus.dout_valid), 512'(0));
        check_output("midrst_cmpl_valid", 512'(bus.cmpl_valid), 512'(0));
        check_output("midrst_buf_ready", 512'(bus.buf_ready), 512'(0));
        check_output("midrst_din_ready", 512'(bus.din_ready), 512'(0));
        check_output("midrst_dropped", 512'(dropped_bufs), 512'(0));
        bus.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("postrst_cmpl_valid", 512'(bus.cmpl_valid), 512'(0));
        check_output("postrst_pending_beats", 512'(exp_addr_q.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
